// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared op and state encodings for the EX-stage divider
package ex_div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        EX_DIV_IDLE = 2'd0,
        EX_DIV_CALC = 2'd1,
        EX_DIV_FIX  = 2'd2,
        EX_DIV_DONE = 2'd3
    } ex_div_state_e;

    // Odd encodings are the unsigned flavours, upper bit selects remainder.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_dff_en.sv
// rtl/ex_div_dff_en.sv - enabled flop primitive with asynchronous active-high reset
module ex_div_dff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 RV32M divider; DIV_RESULT_CACHE_EN adds a last-result cache
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    ex_div_state_e   state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            cnt_en;

    logic            in_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   rem_sh;
    logic            rem_geq;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] quo_fix, rem_fix;

`ifdef DIV_RESULT_CACHE_EN
    logic            c_vld_q, c_vld_d;
    logic [XLEN-1:0] c_rs1_q, c_rs1_d;
    logic [XLEN-1:0] c_rs2_q, c_rs2_d;
    logic            c_sgn_q, c_sgn_d;
    logic [XLEN-1:0] c_quo_q, c_quo_d;
    logic [XLEN-1:0] c_rem_q, c_rem_d;
    logic [XLEN-1:0] key1_q, key1_d;
    logic [XLEN-1:0] key2_q, key2_d;
    logic            c_hit;
`endif

    assign in_signed = op_is_signed(op_i);
    assign div_zero  = (rs2_i == '0);
    assign div_ovf   = in_signed && (rs1_i == INT_MIN) && (rs2_i == '1);
    assign abs1      = (in_signed && rs1_i[XLEN-1]) ? ('0 - rs1_i) : rs1_i;
    assign abs2      = (in_signed && rs2_i[XLEN-1]) ? ('0 - rs2_i) : rs2_i;

    // Partial remainder keeps its top bit in the compare so large divisors stay exact.
    assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
    assign rem_geq = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh[XLEN-1:0] - dvs_q;

    assign quo_fix = neg_quo_q ? ('0 - dvd_q) : dvd_q;
    assign rem_fix = neg_rem_q ? ('0 - rem_q) : rem_q;

`ifdef DIV_RESULT_CACHE_EN
    assign c_hit = c_vld_q && (rs1_i == c_rs1_q) && (rs2_i == c_rs2_q) && (in_signed == c_sgn_q);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_en    = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);
`ifdef DIV_RESULT_CACHE_EN
        c_vld_d   = c_vld_q;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_sgn_d   = c_sgn_q;
        c_quo_d   = c_quo_q;
        c_rem_d   = c_rem_q;
        key1_d    = key1_q;
        key2_d    = key2_q;
`endif
        case (state_q)
            EX_DIV_IDLE: begin
                if (start_i) begin
                    op_d = op_i;
                    if (div_zero) begin
                        result_d = op_is_rem(op_i) ? rs1_i : '1;
                        state_d  = EX_DIV_DONE;
                    end else if (div_ovf) begin
                        result_d = op_is_rem(op_i) ? '0 : INT_MIN;
                        state_d  = EX_DIV_DONE;
`ifdef DIV_RESULT_CACHE_EN
                    end else if (c_hit) begin
                        result_d = op_is_rem(op_i) ? c_rem_q : c_quo_q;
                        state_d  = EX_DIV_DONE;
`endif
                    end else begin
                        dvd_d     = abs1;
                        dvs_d     = abs2;
                        rem_d     = '0;
                        neg_quo_d = in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                        neg_rem_d = in_signed && rs1_i[XLEN-1];
                        cnt_en    = 1'b1;
                        cnt_d     = '0;
                        state_d   = EX_DIV_CALC;
`ifdef DIV_RESULT_CACHE_EN
                        key1_d    = rs1_i;
                        key2_d    = rs2_i;
`endif
                    end
                end
            end
            EX_DIV_CALC: begin
                cnt_en = 1'b1;
                rem_d  = rem_geq ? rem_sub : rem_sh[XLEN-1:0];
                dvd_d  = {dvd_q[XLEN-2:0], rem_geq};
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = EX_DIV_FIX;
                end
            end
            EX_DIV_FIX: begin
                result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                state_d  = EX_DIV_DONE;
`ifdef DIV_RESULT_CACHE_EN
                c_vld_d  = 1'b1;
                c_rs1_d  = key1_q;
                c_rs2_d  = key2_q;
                c_sgn_d  = op_is_signed(op_q);
                c_quo_d  = quo_fix;
                c_rem_d  = rem_fix;
`endif
            end
            EX_DIV_DONE: begin
                state_d = EX_DIV_IDLE;
            end
            default: begin
                state_d = EX_DIV_IDLE;
            end
        endcase

        // Flush overrides everything: no start, no completion, result untouched.
        if (flush_i) begin
            state_d  = EX_DIV_IDLE;
            result_d = result_q;
            op_d     = op_q;
`ifdef DIV_RESULT_CACHE_EN
            if (state_q == EX_DIV_CALC || state_q == EX_DIV_FIX) begin
                c_vld_d = 1'b0;
            end else begin
                c_vld_d = c_vld_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EX_DIV_IDLE;
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_vld_q <= 1'b0;
            c_rs1_q <= '0;
            c_rs2_q <= '0;
            c_sgn_q <= 1'b0;
            c_quo_q <= '0;
            c_rem_q <= '0;
            key1_q  <= '0;
            key2_q  <= '0;
        end else begin
            c_vld_q <= c_vld_d;
            c_rs1_q <= c_rs1_d;
            c_rs2_q <= c_rs2_d;
            c_sgn_q <= c_sgn_d;
            c_quo_q <= c_quo_d;
            c_rem_q <= c_rem_d;
            key1_q  <= key1_d;
            key2_q  <= key2_d;
        end
    end
`endif

    ex_div_dff_en #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (cnt_en),
        .d_i  (cnt_d),
        .q_o  (cnt_q)
    );

    assign busy_o   = (state_q == EX_DIV_CALC) || (state_q == EX_DIV_FIX);
    assign done_o   = (state_q == EX_DIV_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div (cache checks under DIV_RESULT_CACHE_EN)
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    ex_div #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op from IDLE; lat is the cycle of done_o counted from the start cycle, -1 on timeout.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n, output logic [31:0] res);
        @(posedge clk); #1;
        op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
        lat = -1; busy_n = 0; res = 'x;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (busy_o) busy_n++;
            if (done_o) begin
                lat = n;
                res = result_o;
            end
        end
        if (lat < 0) res = result_o;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy_o, done_o} !== 2'b00 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_in: busy=%b done=%b result=%h expected 0 0 0", busy_o, done_o, result_o);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_o, done_o} !== 2'b00 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: busy=%b done=%b result=%h expected 0 0 0", busy_o, done_o, result_o);
        end
    endtask

    task automatic test_unsigned;
        int lat, bn;
        logic [31:0] r;
        do_op(2'b01, 32'd100, 32'd7, lat, bn, r);
        checks++;
        if (lat !== 34 || bn !== 33 || r !== 32'd14) begin
            errors++;
            $display("FAIL divu_100_7: lat=%0d busy=%0d res=%h expected 34 33 0000000e", lat, bn, r);
        end
        do_op(2'b11, 32'd100, 32'd7, lat, bn, r);
        checks++;
        if (r !== 32'd2) begin
            errors++;
            $display("FAIL remu_100_7: res=%h expected 00000002", r);
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'hC000_0000, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'd1) begin
            errors++;
            $display("FAIL divu_big: lat=%0d res=%h expected 34 00000001", lat, r);
        end
        do_op(2'b11, 32'hFFFF_FFFF, 32'hC000_0000, lat, bn, r);
        checks++;
        if (r !== 32'h3FFF_FFFF) begin
            errors++;
            $display("FAIL remu_big: res=%h expected 3fffffff", r);
        end
    endtask

    task automatic test_signed;
        int lat, bn;
        logic [31:0] r;
        do_op(2'b00, 32'hFFFF_FF9C, 32'd7, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'hFFFF_FFF2) begin
            errors++;
            $display("FAIL div_m100_7: lat=%0d res=%h expected 34 fffffff2", lat, r);
        end
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, lat, bn, r);
        checks++;
        if (r !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL rem_m100_7: res=%h expected fffffffe", r);
        end
        do_op(2'b10, 32'd100, 32'hFFFF_FFF9, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'd2) begin
            errors++;
            $display("FAIL rem_100_m7: lat=%0d res=%h expected 34 00000002", lat, r);
        end
    endtask

    task automatic test_special;
        int lat, bn;
        logic [31:0] r;
        do_op(2'b00, 32'd5, 32'd0, lat, bn, r);
        checks++;
        if (lat !== 1 || bn !== 0 || r !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_by0: lat=%0d busy=%0d res=%h expected 1 0 ffffffff", lat, bn, r);
        end
        do_op(2'b10, 32'd5, 32'd0, lat, bn, r);
        checks++;
        if (lat !== 1 || r !== 32'd5) begin
            errors++;
            $display("FAIL rem_by0: lat=%0d res=%h expected 1 00000005", lat, r);
        end
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, r);
        checks++;
        if (lat !== 1 || r !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf: lat=%0d res=%h expected 1 80000000", lat, r);
        end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, r);
        checks++;
        if (lat !== 1 || r !== 32'h0) begin
            errors++;
            $display("FAIL rem_ovf: lat=%0d res=%h expected 1 00000000", lat, r);
        end
    endtask

    task automatic test_flush;
        int lat, bn, dn;
        logic [31:0] r;
        do_op(2'b01, 32'd100, 32'd7, lat, bn, r);
        @(posedge clk); #1;
        op_i = 2'b01; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: busy=%b expected 0", busy_o);
        end
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done_o) dn++;
        end
        checks++;
        if (dn !== 0 || result_o !== 32'd14) begin
            errors++;
            $display("FAIL flush_nodone: dones=%0d result=%h expected 0 0000000e", dn, result_o);
        end
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        do_op(2'b01, 32'd9, 32'd3, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'd3) begin
            errors++;
            $display("FAIL after_flush: lat=%0d res=%h expected 34 00000003", lat, r);
        end
    endtask

    task automatic test_reset_mid;
        int lat, dn;
        logic [31:0] r;
        @(posedge clk); #1;
        op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o} !== 2'b00 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0", busy_o, done_o, result_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        lat = -1; dn = 0; r = '0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            start_i = (n == 5);
            if (n == 5) begin
                op_i = 2'b11; rs1_i = 32'd9; rs2_i = 32'd3;
            end
            if (done_o) begin
                dn++;
                if (lat < 0) begin
                    lat = n;
                    r = result_o;
                end
            end
        end
        checks++;
        if (lat !== 34 || dn !== 1 || r !== 32'd14) begin
            errors++;
            $display("FAIL start_while_busy: lat=%0d dones=%0d res=%h expected 34 1 0000000e", lat, dn, r);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        logic [31:0] r;
        do_op(2'b00, 32'd77, 32'd5, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'd15) begin
            errors++;
            $display("FAIL div_77_5: lat=%0d res=%h expected 34 0000000f", lat, r);
        end
        do_op(2'b10, 32'd77, 32'd5, lat, bn, r);
        checks++;
`ifdef DIV_RESULT_CACHE_EN
        if (lat !== 1 || r !== 32'd2) begin
            errors++;
            $display("FAIL rem_77_5_hit: lat=%0d res=%h expected 1 00000002", lat, r);
        end
`else
        if (lat !== 34 || r !== 32'd2) begin
            errors++;
            $display("FAIL rem_77_5: lat=%0d res=%h expected 34 00000002", lat, r);
        end
`endif
        do_op(2'b01, 32'd77, 32'd5, lat, bn, r);
        checks++;
        if (lat !== 34 || r !== 32'd15) begin
            errors++;
            $display("FAIL divu_77_5: lat=%0d res=%h expected 34 0000000f", lat, r);
        end
        // Still in the DONE cycle: a start here must be dropped.
        op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd15) begin
            errors++;
            $display("FAIL start_in_done: busy=%b done=%b result=%h expected 0 0 0000000f", busy_o, done_o, result_o);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = 2'b00; rs1_i = '0; rs2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_unsigned;
        test_signed;
        test_special;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
